urisc_mem_arbiter: RTL and testbench

- Owns the single-port 8-bit program/data RAM that the URISC core and an external host loader both use.
- Sequences the core through idle, run, drain and done, and drives its RUN input.
- Grants host read/write access only while the core is stopped at an instruction boundary.
- Provides a run watchdog and a cycle counter so runaway programs are stopped and measured.

---
 rtl/urisc_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_urisc_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/urisc_mem_arbiter.sv
// rtl/urisc_mem_arbiter.sv - single-port RAM arbiter, run sequencer and watchdog for the URISC core
module urisc_mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk_PH1,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              core_run,
    input  logic              core_ifetch,
    input  logic              core_csmr,
    input  logic              core_rdmr,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_ACC,
        S_HOST_RSP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_RUN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state, state_nxt;
    logic              ret_done;
    logic              timeout_q;
    logic [CNT_W-1:0]  run_cnt;
    logic [DATA_W-1:0] host_rdata_q;
    logic              stopped;
    logic              core_owns;
    logic              wd_hit;

    assign stopped   = (state == S_IDLE) || (state == S_DONE);
    assign core_owns = (state == S_RUN) || (state == S_DRAIN);
    assign wd_hit    = (state == S_RUN) && (run_cnt >= WD_LIMIT);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start)         state_nxt = S_RUN;
                else if (host_req) state_nxt = S_HOST_ACC;
            end
            S_HOST_ACC: state_nxt = S_HOST_RSP;
            S_HOST_RSP: state_nxt = ret_done ? S_DONE : S_IDLE;
            S_RUN:      if (stop || wd_hit) state_nxt = S_DRAIN;
            // Only leave DRAIN at an instruction boundary so the core is never cut mid-instruction.
            S_DRAIN:    if (core_ifetch) state_nxt = S_DONE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_PH1) begin
        if (rst) begin
            state        <= S_IDLE;
            ret_done     <= 1'b0;
            timeout_q    <= 1'b0;
            run_cnt      <= '0;
            host_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (stopped && start) begin
                run_cnt   <= '0;
                timeout_q <= 1'b0;
            end else if (core_owns && run_cnt != CNT_MAX) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (wd_hit) timeout_q <= 1'b1;
            if (stopped && !start && host_req) ret_done <= (state == S_DONE);
            if (state == S_HOST_RSP) host_rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        if (core_owns) begin
            mem_cs    = core_csmr & (core_rdmr | core_write);
            mem_we    = core_write;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (state == S_HOST_ACC) begin
            mem_cs = 1'b1;
            mem_we = host_we;
        end
    end

    // Read data is live during the ack cycle and held afterwards.
    assign host_rdata = (state == S_HOST_RSP) ? mem_rdata : host_rdata_q;
    assign host_ack   = (state == S_HOST_RSP);
    assign core_rdata = mem_rdata;
    assign core_run   = core_owns;
    assign busy       = core_owns;
    assign done       = (state == S_DONE);
    assign timeout    = timeout_q;
    assign run_cycles = run_cnt;

endmodule

// File: tb/tb_urisc_mem_arbiter.sv
// tb/tb_urisc_mem_arbiter.sv - self-checking bench for urisc_mem_arbiter
module tb_urisc_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MR = 20;
    localparam int CW = 16;

    logic          clk_PH1 = 1'b0;
    logic          rst, start, stop, core_run, core_ifetch;
    logic          core_csmr, core_rdmr, core_write;
    logic [AW-1:0] core_addr, host_addr, mem_addr;
    logic [DW-1:0] core_wdata, core_rdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
    logic          host_req, host_we, host_ack, mem_cs, mem_we, busy, done, timeout;
    logic [CW-1:0] run_cycles;

    logic [DW-1:0] ram    [256];
    logic [DW-1:0] shadow [256];
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } host_vec_t;

    typedef struct {
        int stop_k;
        int w;
        bit fa;
        int exp_cycles;
        bit exp_to;
    } run_vec_t;

    host_vec_t hv [8];
    run_vec_t  rv [6];

    urisc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RUN(MR), .CNT_W(CW)) dut (
        .clk_PH1(clk_PH1), .rst(rst), .start(start), .stop(stop),
        .core_run(core_run), .core_ifetch(core_ifetch), .core_csmr(core_csmr),
        .core_rdmr(core_rdmr), .core_write(core_write), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .host_req(host_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk_PH1 = ~clk_PH1;

    always @(posedge clk_PH1) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk_PH1);
        #1;
    endtask

    // Run outcome from the rules: DRAIN begins at the stop edge or at watchdog edge MR,
    // and ends on the first DRAIN edge that sees core_ifetch.
    function automatic int drain_edge(input int stop_k);
        return (stop_k >= 1 && stop_k <= MR) ? stop_k : MR;
    endfunction

    function automatic int model_exit(input int stop_k, input int w, input bit fa);
        return drain_edge(stop_k) + (fa ? 1 : w + 1);
    endfunction

    function automatic bit model_to(input int stop_k);
        return !(stop_k >= 1 && stop_k < MR);
    endfunction

    task automatic host_access(input bit we, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic [DW-1:0] exp);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
        step;
        chk("acc_cs", 32'(mem_cs), 32'(1));
        chk("acc_we", 32'(mem_we), 32'(we));
        chk("acc_addr", 32'(mem_addr), 32'(a));
        chk("acc_noack", 32'(host_ack), 32'(0));
        if (we) chk("acc_wdata", 32'(mem_wdata), 32'(wd));
        step;
        chk("rsp_ack", 32'(host_ack), 32'(1));
        chk("rsp_run", 32'(core_run), 32'(0));
        if (!we) chk("rsp_rdata", 32'(host_rdata), 32'(exp));
        host_req = 1'b0;
        step;
        chk("ack_pulse", 32'(host_ack), 32'(0));
        if (we) shadow[a] = wd;
    endtask

    task automatic do_run(input int stop_k, input int w, input bit fa,
                          input int exp_cycles, input bit exp_to);
        int ex;
        ex = model_exit(stop_k, w, fa);
        start = 1'b1; core_ifetch = fa;
        step;
        start = 1'b0;
        chk("run_start", 32'(core_run), 32'(1));
        chk("run_busy", 32'(busy), 32'(1));
        chk("run_to_clr", 32'(timeout), 32'(0));
        chk("run_cnt0", 32'(run_cycles), 32'(0));
        for (int k = 1; k <= ex; k++) begin
            stop        = (k == stop_k);
            start       = ($urandom_range(0, 7) == 0);
            core_ifetch = fa || (k == ex);
            core_csmr   = $urandom_range(0, 1) == 1;
            core_rdmr   = $urandom_range(0, 1) == 1;
            core_write  = $urandom_range(0, 3) == 0;
            core_addr   = AW'($urandom);
            core_wdata  = DW'($urandom);
            #1;
            chk("run_mem_cs", 32'(mem_cs), 32'(core_csmr & (core_rdmr | core_write)));
            chk("run_mem_we", 32'(mem_we), 32'(core_write));
            chk("run_mem_addr", 32'(mem_addr), 32'(core_addr));
            chk("run_mem_wdata", 32'(mem_wdata), 32'(core_wdata));
            chk("run_core_rdata", 32'(core_rdata), 32'(mem_rdata));
            chk("run_live", 32'(core_run), 32'(1));
            chk("run_noack", 32'(host_ack), 32'(0));
            if (core_csmr && core_write) shadow[core_addr] = core_wdata;
            @(posedge clk_PH1);
            #1;
        end
        stop = 1'b0; start = 1'b0; core_ifetch = 1'b0;
        core_csmr = 1'b0; core_rdmr = 1'b0; core_write = 1'b0;
        chk("end_run", 32'(core_run), 32'(0));
        chk("end_done", 32'(done), 32'(1));
        chk("end_busy", 32'(busy), 32'(0));
        chk("end_cycles", 32'(run_cycles), 32'(exp_cycles));
        chk("end_timeout", 32'(timeout), 32'(exp_to));
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        int sk, ww;
        bit ff;

        for (int i = 0; i < 256; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        mem_rdata = '0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; core_ifetch = 1'b0;
        core_csmr = 1'b0; core_rdmr = 1'b0; core_write = 1'b0;
        core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        hv[0] = '{1'b1, 8'h10, 8'h05, 8'h00};
        hv[1] = '{1'b0, 8'h10, 8'h00, 8'h05};
        hv[2] = '{1'b1, 8'h00, 8'hA5, 8'h00};
        hv[3] = '{1'b1, 8'hFF, 8'h3C, 8'h00};
        hv[4] = '{1'b0, 8'h00, 8'h00, 8'hA5};
        hv[5] = '{1'b0, 8'hFF, 8'h00, 8'h3C};
        hv[6] = '{1'b1, 8'h10, 8'hFF, 8'h00};
        hv[7] = '{1'b0, 8'h10, 8'h00, 8'hFF};

        rv[0] = '{10, 2, 1'b0, 13, 1'b0};
        rv[1] = '{0,  0, 1'b1, 21, 1'b1};
        rv[2] = '{1,  0, 1'b0, 2,  1'b0};
        rv[3] = '{19, 0, 1'b0, 20, 1'b0};
        rv[4] = '{5,  0, 1'b1, 6,  1'b0};
        rv[5] = '{20, 1, 1'b0, 22, 1'b1};

        step; step;
        chk("rst_state_run", 32'(core_run), 32'(0));
        chk("rst_ack", 32'(host_ack), 32'(0));
        chk("rst_cs", 32'(mem_cs), 32'(0));
        chk("rst_we", 32'(mem_we), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
        chk("rst_cycles", 32'(run_cycles), 32'(0));
        chk("rst_rdata", 32'(host_rdata), 32'(0));
        rst = 1'b0;
        step;

        for (int i = 0; i < 8; i++) host_access(hv[i].we, hv[i].addr, hv[i].wdata, hv[i].exp);

        for (int i = 0; i < 6; i++) do_run(rv[i].stop_k, rv[i].w, rv[i].fa, rv[i].exp_cycles, rv[i].exp_to);

        // timeout is sticky through host traffic and stop pulses in DONE
        host_access(1'b1, 8'h10, 8'h5A, 8'h00);
        chk("to_sticky", 32'(timeout), 32'(1));
        chk("done_after_host", 32'(done), 32'(1));
        stop = 1'b1;
        step;
        stop = 1'b0;
        chk("stop_ign_done", 32'(done), 32'(1));
        chk("stop_ign_run", 32'(core_run), 32'(0));

        // start and host_req together: run wins, host is served 2 cycles after DONE
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        do_run(4, 1, 1'b0, 6, 1'b0);
        chk("cont_noack_done", 32'(host_ack), 32'(0));
        step;
        chk("cont_acc_cs", 32'(mem_cs), 32'(1));
        chk("cont_acc_addr", 32'(mem_addr), 32'(8'h10));
        chk("cont_acc_noack", 32'(host_ack), 32'(0));
        step;
        chk("cont_ack", 32'(host_ack), 32'(1));
        chk("cont_rdata", 32'(host_rdata), 32'(shadow[8'h10]));
        host_req = 1'b0;
        step;
        chk("cont_back_done", 32'(done), 32'(1));

        for (int n = 0; n < 30; n++) begin
            ra = AW'($urandom);
            rd = DW'($urandom);
            case ($urandom_range(0, 2))
                0: host_access(1'b1, ra, rd, 8'h00);
                1: host_access(1'b0, ra, 8'h00, shadow[ra]);
                default: begin
                    sk = $urandom_range(0, 24);
                    ww = $urandom_range(0, 3);
                    ff = $urandom_range(0, 1) == 1;
                    do_run(sk, ww, ff, model_exit(sk, ww, ff), model_to(sk));
                end
            endcase
        end

        // reset mid-run
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (5) step;
        rst = 1'b1;
        step;
        chk("rrun_core_run", 32'(core_run), 32'(0));
        chk("rrun_cycles", 32'(run_cycles), 32'(0));
        chk("rrun_busy", 32'(busy), 32'(0));
        chk("rrun_done", 32'(done), 32'(0));
        rst = 1'b0;
        step;

        // reset mid host access: the interrupted read never acks
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h33;
        step;
        chk("racc_cs", 32'(mem_cs), 32'(1));
        rst = 1'b1; host_req = 1'b0;
        step;
        chk("racc_ack", 32'(host_ack), 32'(0));
        chk("racc_cs_off", 32'(mem_cs), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("racc_noack", 32'(host_ack), 32'(0));
        end
        chk("racc_idle_run", 32'(core_run), 32'(0));
        chk("racc_idle_done", 32'(done), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
